// File: rtl/alu_exec_ctrl.sv
// Register-file execution controller that feeds an external 8-bit ALU through IDLE -> EXEC -> RESP.
// Optional sticky overflow status is enabled by defining ALU_EXEC_STICKY_OVF_EN.
module alu_exec_ctrl #(
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic          instr_imm_en,
  input  logic [7:0]    instr_imm,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_ctrl,
  input  logic [7:0]    alu_result,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  input  logic          alu_carry,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic [AW-1:0] res_rd,
  output logic [2:0]    res_flags,
  output logic          res_illegal,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data,
  output logic          ovf_sticky,
  input  logic          clr_sticky
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [AW-1:0] res_rd_q, res_rd_d;
  logic [2:0]    res_flags_q, res_flags_d;
  logic          res_illegal_q, res_illegal_d;
  logic [7:0]    regs_q [NREG];
  logic [7:0]    regs_d [NREG];
  logic          op_legal;

  // The op code is held in alu_ctrl_q for the whole instruction, so legality is derived from it.
  assign op_legal = (alu_ctrl_q <= 4'hA);

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    rd_d          = rd_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_flags_d   = res_flags_q;
    res_illegal_d = res_illegal_q;
    regs_d        = regs_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          alu_a_d    = regs_q[instr_rs1];
          alu_b_d    = instr_imm_en ? instr_imm : regs_q[instr_rs2];
          alu_ctrl_d = instr_op;
          rd_d       = instr_rd;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_data_d    = alu_result;
        res_flags_d   = {alu_carry, alu_overflow, alu_zero};
        res_rd_d      = rd_q;
        res_illegal_d = !op_legal;
        if (op_legal) begin
          regs_d[rd_q] = alu_result;
        end
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      alu_a_q       <= 8'h00;
      alu_b_q       <= 8'h00;
      alu_ctrl_q    <= 4'h0;
      rd_q          <= '0;
      res_data_q    <= 8'h00;
      res_rd_q      <= '0;
      res_flags_q   <= 3'b000;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      rd_q          <= rd_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_flags_q   <= res_flags_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  // Register file kept in flops: every entry must clear on the asynchronous reset.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[gi] <= 8'h00;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end
  end

`ifdef ALU_EXEC_STICKY_OVF_EN
  logic ovf_sticky_q, ovf_sticky_d;

  // A set in EXEC overrides a simultaneous clear.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
    end
    if (state_q == EXEC && op_legal && alu_overflow) begin
      ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign ovf_sticky        = 1'b0;
`endif

  assign instr_ready = (state_q == IDLE);
  assign res_valid   = (state_q == RESP);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_flags   = res_flags_q;
  assign res_illegal = res_illegal_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU stub, register-file model, directed then random instructions.
// Honours ALU_EXEC_STICKY_OVF_EN the same way as the design.
module tb_alu_exec_ctrl;
  localparam int NREG = 4;
  localparam int AW   = 2;
`ifdef ALU_EXEC_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid, instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          instr_imm_en;
  logic [7:0]    instr_imm;
  logic [7:0]    alu_a, alu_b;
  logic [3:0]    alu_ctrl;
  logic [7:0]    alu_result;
  logic          alu_zero, alu_overflow, alu_carry;
  logic          res_valid, res_ready;
  logic [7:0]    res_data;
  logic [AW-1:0] res_rd;
  logic [2:0]    res_flags;
  logic          res_illegal;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;
  logic          ovf_sticky, clr_sticky;

  int total = 0;
  int bad   = 0;
  logic [7:0] mreg [NREG];
  logic       exp_sticky;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_flags(res_flags), .res_illegal(res_illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  // Downstream ALU behaviour: returns {carry, overflow, zero, result}. Illegal ops yield 0.
  function automatic logic [10:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    logic [7:0] r;
    logic c, v;
    r = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255);
                  v = (int'($signed(a)) + int'($signed(b)) > 127) || (int'($signed(a)) + int'($signed(b)) < -128); end
      4'h1: begin s = int'(a) - int'(b); r = s[7:0]; c = (s < 0);
                  v = (int'($signed(a)) - int'($signed(b)) > 127) || (int'($signed(a)) - int'($signed(b)) < -128); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'h6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'h7: r = b;
      4'h8: r = ~a;
      4'h9: begin r = a + 8'd1; v = (a == 8'h7F); c = (a == 8'hFF); end
      4'hA: begin r = a - 8'd1; v = (a == 8'h80); c = (a == 8'h00); end
      default: r = 8'h00;
    endcase
    return {c, v, (r == 8'h00), r};
  endfunction

  assign {alu_carry, alu_overflow, alu_zero, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mreg[i] = 8'h00;
    exp_sticky = 1'b0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = i[AW-1:0];
      #1;
      check(tag, {24'h0, dbg_data}, {24'h0, mreg[i]});
    end
  endtask

  // One full instruction: transfer, EXEC, RESP held for 'hold' cycles, then accepted.
  task automatic do_instr(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                          input logic ie, input logic [7:0] imm, input int hold,
                          input logic clr, input logic early_rdy);
    logic [7:0]  a, b;
    logic [10:0] f;
    logic        ill;
    a   = mreg[rs1];
    b   = ie ? imm : mreg[rs2];
    f   = alu_fn(op, a, b);
    ill = (op > 4'hA);
    check("idle_instr_ready", {31'h0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd[AW-1:0];
    instr_rs1 = rs1[AW-1:0]; instr_rs2 = rs2[AW-1:0]; instr_imm_en = ie; instr_imm = imm;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_op = 4'($urandom); instr_imm = 8'($urandom); instr_rs1 = AW'($urandom);
    check("exec_alu_a", {24'h0, alu_a}, {24'h0, a});
    check("exec_alu_b", {24'h0, alu_b}, {24'h0, b});
    check("exec_alu_ctrl", {28'h0, alu_ctrl}, {28'h0, op});
    check("exec_res_valid", {31'h0, res_valid}, 32'd0);
    check("exec_instr_ready", {31'h0, instr_ready}, 32'd0);
    res_ready = early_rdy; clr_sticky = clr;
    @(posedge clk); #1;
    res_ready = 1'b0; clr_sticky = 1'b0;
    if (!ill) mreg[rd] = f[7:0];
    exp_sticky = STICKY & ((exp_sticky & ~clr) | (~ill & f[9]));
    check("resp_res_valid", {31'h0, res_valid}, 32'd1);
    check("resp_res_data", {24'h0, res_data}, {24'h0, f[7:0]});
    check("resp_res_flags", {29'h0, res_flags}, {29'h0, f[10:8]});
    check("resp_res_rd", {30'h0, res_rd}, 32'(rd));
    check("resp_res_illegal", {31'h0, res_illegal}, {31'h0, ill});
    check("resp_ovf_sticky", {31'h0, ovf_sticky}, {31'h0, exp_sticky});
    dbg_addr = rd[AW-1:0];
    #1;
    check("resp_dbg_data", {24'h0, dbg_data}, {24'h0, mreg[rd]});
    $display("txn op=%h rd=%0d rs1=%0d rs2=%0d imm_en=%0b a=%h b=%h res=%h flags=%b ill=%0b hold=%0d",
             op, rd, rs1, rs2, ie, a, b, f[7:0], f[10:8], ill, hold);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_res_valid", {31'h0, res_valid}, 32'd1);
      check("hold_res_data", {24'h0, res_data}, {24'h0, f[7:0]});
      check("hold_res_flags", {29'h0, res_flags}, {29'h0, f[10:8]});
      check("hold_res_rd", {30'h0, res_rd}, 32'(rd));
      check("hold_instr_ready", {31'h0, instr_ready}, 32'd0);
      check("hold_alu_a", {24'h0, alu_a}, {24'h0, a});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("done_res_valid", {31'h0, res_valid}, 32'd0);
    check("done_instr_ready", {31'h0, instr_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = 4'h0; instr_rd = '0; instr_rs1 = '0;
    instr_rs2 = '0; instr_imm_en = 1'b0; instr_imm = 8'h00; res_ready = 1'b0;
    dbg_addr = '0; clr_sticky = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a", {24'h0, alu_a}, 32'h0);
    check("rst_alu_b", {24'h0, alu_b}, 32'h0);
    check("rst_alu_ctrl", {28'h0, alu_ctrl}, 32'h0);
    check("rst_res_data", {24'h0, res_data}, 32'h0);
    check("rst_res_rd", {30'h0, res_rd}, 32'h0);
    check("rst_res_flags", {29'h0, res_flags}, 32'h0);
    check("rst_res_illegal", {31'h0, res_illegal}, 32'h0);
    check("rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("rst_ovf_sticky", {31'h0, ovf_sticky}, 32'h0);
    check_all_regs("rst_reg");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_instr_ready", {31'h0, instr_ready}, 32'd1);

    // 0x00+0x7F then 0x7F+0x01: signed overflow into 0x80.
    do_instr(4'h0, 1, 0, 0, 1'b1, 8'h7F, 0, 1'b0, 1'b0);
    do_instr(4'h0, 2, 1, 0, 1'b1, 8'h01, 0, 1'b0, 1'b0);
    check("d032_res_flags", {29'h0, res_flags}, 32'b010);
    dbg_addr = 2'd2; #1;
    check("d032_dbg2", {24'h0, dbg_data}, 32'h80);
    check("d037_sticky_set", {31'h0, ovf_sticky}, {31'h0, STICKY});
    // reg1 - reg1 -> zero, held 5 cycles in RESP.
    do_instr(4'h1, 3, 1, 1, 1'b0, 8'h00, 5, 1'b0, 1'b0);
    check("d033_res_data", {24'h0, res_data}, 32'h00);
    check("d037_sticky_keep", {31'h0, ovf_sticky}, {31'h0, STICKY});
    // Illegal op: no write to reg1.
    do_instr(4'hC, 1, 2, 3, 1'b0, 8'h00, 1, 1'b0, 1'b1);
    dbg_addr = 2'd1; #1;
    check("d035_reg1_kept", {24'h0, dbg_data}, 32'h7F);
    check("d035_illegal", {31'h0, res_illegal}, 32'd1);
    // Clear pulse outside EXEC.
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    exp_sticky = 1'b0;
    check("d037_sticky_clr", {31'h0, ovf_sticky}, 32'd0);

    // Reset during EXEC aborts the instruction.
    instr_valid = 1'b1; instr_op = 4'h0; instr_rd = 2'd2; instr_rs1 = 2'd0;
    instr_imm_en = 1'b1; instr_imm = 8'h55;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("d036_res_valid", {31'h0, res_valid}, 32'd0);
    check("d036_sticky", {31'h0, ovf_sticky}, 32'd0);
    check_all_regs("d036_reg");
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("d036_instr_ready", {31'h0, instr_ready}, 32'd1);
    check("d036_res_valid_after", {31'h0, res_valid}, 32'd0);
    check_all_regs("d036_reg_after");

    // Randomised instructions against the model.
    for (int n = 0; n < 60; n++) begin
      do_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, NREG - 1)),
               int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
               1'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom));
    end
    check_all_regs("final_reg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
